// File: rtl/dlx_global_pkg.sv
// Shared DLX definitions: the word type, the NOP encoding and fetch-stage defaults.
// The NOP is the special-opcode group with the nop function field.
package dlx_global_pkg;

  typedef logic [31:0] dlx_word;

  localparam logic [5:0] op_special = 6'h00;
  localparam logic [5:0] sp_nop     = 6'h00;

  localparam dlx_word DLX_NOP = {op_special, 20'h0_0000, sp_nop};

  localparam dlx_word DLX_PC_INCR      = 32'd4;
  localparam dlx_word DLX_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } if_state_t;

endpackage

// File: rtl/dlx_if_skid_buf.sv
// One-entry holding slot for a fetched word that arrives while the pipe is held.
// Flush beats load, and load beats drain.
module dlx_if_skid_buf
  import dlx_global_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_load,
  input  logic    i_drain,
  input  logic    i_flush,
  input  dlx_word i_ir,
  input  dlx_word i_npc,
  output logic    o_valid,
  output logic    o_valid_next,
  output dlx_word o_ir,
  output dlx_word o_npc
);

  logic    r_valid;
  dlx_word r_ir;
  dlx_word r_npc;
  logic    w_valid_next;

  assign w_valid_next = i_flush ? 1'b0 :
                        i_load  ? 1'b1 :
                        i_drain ? 1'b0 : r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_ir    <= DLX_NOP;
      r_npc   <= '0;
    end else begin
      r_valid <= w_valid_next;
      if (i_load && !i_flush) begin
        r_ir  <= i_ir;
        r_npc <= i_npc;
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_valid_next = w_valid_next;
  assign o_ir         = r_ir;
  assign o_npc        = r_npc;

endmodule

// File: rtl/dlx_pipe_if.sv
// DLX instruction fetch stage: owns the PC, runs a single-outstanding imem
// request/ack handshake and loads the IF/ID pipe register.
module dlx_pipe_if
  import dlx_global_pkg::*;
#(
  parameter dlx_word RESET_VECTOR = DLX_RESET_VECTOR,
  parameter dlx_word PC_INCR      = DLX_PC_INCR
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    stall,
  input  logic    dc_wait,
  input  logic    id_cond,
  input  dlx_word id_npc,
  input  logic    id_halt,
  input  logic    id_illegal_instr,
  output logic    imem_req,
  output dlx_word imem_addr,
  input  dlx_word imem_rdata,
  input  logic    imem_ack,
  output dlx_word if_id_npc,
  output dlx_word if_id_ir,
  output logic    if_halted
);

  if_state_t r_state;
  dlx_word   r_pc;
  dlx_word   r_addr;
  logic      r_req;
  logic      r_drop;
  dlx_word   r_ir;
  dlx_word   r_npc;

  logic    w_fetching;
  logic    w_hold;
  logic    w_ack;
  logic    w_req_busy;
  logic    w_halt_evt;
  logic    w_redir;
  logic    w_take;
  dlx_word w_target;
  dlx_word w_pc_inc;
  dlx_word w_pc_next;

  logic    w_buf_load;
  logic    w_buf_drain;
  logic    w_buf_flush;
  logic    w_buf_valid;
  logic    w_buf_valid_next;
  dlx_word w_buf_ir;
  dlx_word w_buf_npc;

  assign w_fetching = (r_state == FETCH);
  assign w_hold     = stall | dc_wait;
  assign w_ack      = r_req & imem_ack;
  assign w_req_busy = r_req & ~imem_ack;

  // Priority: hold > halt > redirect > sequential delivery.
  assign w_halt_evt = w_fetching & ~w_hold & (id_halt | id_illegal_instr);
  assign w_redir    = w_fetching & ~w_hold & ~w_halt_evt & id_cond;
  assign w_take     = w_fetching & w_ack & ~r_drop & ~w_halt_evt & ~w_redir;

  assign w_target  = id_npc & ~32'd3;
  assign w_pc_inc  = r_pc + PC_INCR;
  assign w_pc_next = w_redir ? w_target : (w_take ? w_pc_inc : r_pc);

  assign w_buf_load  = w_take & w_hold;
  assign w_buf_flush = w_halt_evt | w_redir;
  assign w_buf_drain = w_fetching & ~w_hold & w_buf_valid;

  dlx_if_skid_buf u_skid (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_buf_load),
    .i_drain      (w_buf_drain),
    .i_flush      (w_buf_flush),
    .i_ir         (imem_rdata),
    .i_npc        (w_pc_inc),
    .o_valid      (w_buf_valid),
    .o_valid_next (w_buf_valid_next),
    .o_ir         (w_buf_ir),
    .o_npc        (w_buf_npc)
  );

  // An unacked request keeps its address even across a redirect; r_drop marks
  // its eventual ack as stale so the new PC is fetched only afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_VECTOR;
      r_addr  <= RESET_VECTOR;
      r_req   <= 1'b0;
      r_drop  <= 1'b0;
      r_ir    <= DLX_NOP;
      r_npc   <= RESET_VECTOR;
    end else begin
      r_pc <= w_pc_next;
      unique case (r_state)
        FETCH: begin
          if (w_halt_evt) begin
            r_state <= HALTED;
            r_ir    <= DLX_NOP;
            r_drop  <= 1'b0;
            r_req   <= w_req_busy;
          end else begin
            if (w_redir) begin
              r_ir <= DLX_NOP;
            end else if (!w_hold) begin
              if (w_buf_valid) begin
                r_ir  <= w_buf_ir;
                r_npc <= w_buf_npc;
              end else if (w_take) begin
                r_ir  <= imem_rdata;
                r_npc <= w_pc_inc;
              end else begin
                r_ir <= DLX_NOP;
              end
            end
            if (w_req_busy) begin
              r_drop <= r_drop | w_redir;
            end else begin
              r_req  <= ~(w_hold & w_buf_valid_next);
              r_addr <= w_pc_next;
              r_drop <= 1'b0;
            end
          end
        end
        HALTED: begin
          r_req <= w_req_busy;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_id_ir  = r_ir;
  assign if_id_npc = r_npc;
  assign if_halted = (r_state == HALTED);

endmodule

// File: tb/tb_dlx_pipe_if.sv
// Directed plus randomized bench for dlx_pipe_if, checked against a
// transaction-level model (fetched words flow through a queue).
module tb_dlx_pipe_if;
  import dlx_global_pkg::*;

  localparam dlx_word RV      = 32'h0000_0000;
  localparam dlx_word PC_STEP = 32'd4;

  logic    clk = 1'b0;
  logic    rst;
  logic    stall, dc_wait, id_cond, id_halt, id_illegal_instr;
  dlx_word id_npc;
  logic    imem_req;
  dlx_word imem_addr;
  dlx_word imem_rdata;
  logic    imem_ack;
  dlx_word if_id_npc, if_id_ir;
  logic    if_halted;

  always #5 clk = ~clk;

  dlx_pipe_if #(.RESET_VECTOR(RV), .PC_INCR(PC_STEP)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .dc_wait          (dc_wait),
    .id_cond          (id_cond),
    .id_npc           (id_npc),
    .id_halt          (id_halt),
    .id_illegal_instr (id_illegal_instr),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_ack         (imem_ack),
    .if_id_npc        (if_id_npc),
    .if_id_ir         (if_id_ir),
    .if_halted        (if_halted)
  );

  typedef struct packed {
    dlx_word ir;
    dlx_word npc;
  } fetchEntry_t;

  int errors = 0;
  int checks = 0;

  bit          mReq, mDrop, mHalted;
  dlx_word     mAddr, mPc, mIr, mNpc;
  fetchEntry_t mQ[$];
  int          latLeft  = -1;
  int          latFixed = 1;

  function automatic dlx_word memWord(input dlx_word addr);
    return ((addr >> 2) + 32'd1) * 32'h11;
  endfunction

  task automatic checkOutput(input string tag, input dlx_word got, input dlx_word exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mReq = 0; mDrop = 0; mHalted = 0;
    mAddr = RV; mPc = RV; mIr = DLX_NOP; mNpc = RV;
    mQ.delete();
    latLeft = -1;
  endtask

  // Arriving words join the queue; an unheld pipe takes the oldest one.
  task automatic modelEdge();
    bit hold, acked, keepReq, jump;
    fetchEntry_t f;
    hold    = stall | dc_wait;
    acked   = mReq && imem_ack;
    keepReq = mReq && !imem_ack;
    jump    = !hold && id_cond;
    if (mHalted) begin
      mReq = keepReq;
    end else if (!hold && (id_halt || id_illegal_instr)) begin
      mHalted = 1; mIr = DLX_NOP; mQ.delete(); mDrop = 0; mReq = keepReq;
    end else begin
      if (acked && !mDrop && !jump) begin
        mQ.push_back({imem_rdata, mPc + PC_STEP});
        mPc = mPc + PC_STEP;
      end
      if (jump) begin
        mQ.delete();
        mIr = DLX_NOP;
        mPc = id_npc & 32'hFFFF_FFFC;
      end else if (!hold) begin
        if (mQ.size() > 0) begin
          f = mQ.pop_front();
          mIr = f.ir; mNpc = f.npc;
        end else begin
          mIr = DLX_NOP;
        end
      end
      if (keepReq) begin
        mDrop = mDrop || jump;
      end else begin
        mReq = !(hold && mQ.size() > 0);
        mAddr = mPc;
        mDrop = 0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("imem_req", dlx_word'(imem_req), dlx_word'(mReq));
    if (mReq) checkOutput("imem_addr", imem_addr, mAddr);
    checkOutput("if_id_ir", if_id_ir, mIr);
    checkOutput("if_id_npc", if_id_npc, mNpc);
    checkOutput("if_halted", dlx_word'(if_halted), dlx_word'(mHalted));
  endtask

  // Called at a falling edge; plays memory, advances the model, clocks once.
  task automatic applyStimulus(input bit iStall, input bit iDc, input bit iCond,
                               input dlx_word iNpc, input bit iHalt, input bit iIll);
    stall = iStall; dc_wait = iDc; id_cond = iCond; id_npc = iNpc;
    id_halt = iHalt; id_illegal_instr = iIll;
    if (mReq) begin
      if (latLeft < 0) latLeft = (latFixed > 0) ? latFixed - 1 : int'($urandom_range(0, 2));
      imem_ack = (latLeft == 0);
      if (imem_ack) begin
        imem_rdata = memWord(mAddr);
        latLeft = -1;
      end else begin
        imem_rdata = $urandom();
        latLeft--;
      end
    end else begin
      imem_ack = 0; imem_rdata = $urandom(); latLeft = -1;
    end
    modelEdge();
    @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic asyncReset();
    #2 rst = 0;
    #1;
    imem_ack = 0;
    modelReset();
    checkOutput("rst_req", dlx_word'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, RV);
    checkOutput("rst_ir", if_id_ir, DLX_NOP);
    checkOutput("rst_npc", if_id_npc, RV);
    checkOutput("rst_halted", dlx_word'(if_halted), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    rst = 1; stall = 0; dc_wait = 0; id_cond = 0; id_npc = '0;
    id_halt = 0; id_illegal_instr = 0; imem_ack = 0; imem_rdata = '0;
    #1 rst = 0;
    modelReset();
    @(negedge clk);
    checkOutput("reset_req", dlx_word'(imem_req), 32'd0);
    checkOutput("reset_ir", if_id_ir, DLX_NOP);
    checkOutput("reset_npc", if_id_npc, RV);
    checkOutput("reset_halted", dlx_word'(if_halted), 32'd0);
    rst = 1;

    // Back-to-back single-cycle acks.
    latFixed = 1;
    idle(4);
    checkOutput("seq_ir", if_id_ir, 32'h33);
    checkOutput("seq_npc", if_id_npc, 32'd12);

    // Ack of 0x44 lands while stalled; word is parked and delivered afterwards.
    applyStimulus(1, 0, 0, 32'h0, 0, 0);
    checkOutput("stall_frozen_ir", if_id_ir, 32'h33);
    applyStimulus(0, 1, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkOutput("stall_buf_ir", if_id_ir, 32'h44);
    checkOutput("stall_buf_npc", if_id_npc, 32'd16);

    // Three-cycle ack latency.
    latFixed = 3;
    idle(3);
    checkOutput("lat3_ir", if_id_ir, 32'h55);

    // Redirect while a request is outstanding; its ack must be dropped.
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 1, 32'h0000_0103, 0, 0);
    checkOutput("redir_squash_ir", if_id_ir, DLX_NOP);
    latFixed = 1;
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkOutput("redir_new_addr", imem_addr, 32'h100);
    checkOutput("redir_drop_ir", if_id_ir, DLX_NOP);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkOutput("redir_target_ir", if_id_ir, 32'h451);

    // Redirect near the top of the address space; the PC wraps to zero.
    applyStimulus(0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    idle(2);
    checkOutput("wrap_npc", if_id_npc, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    // Halt with a redirect in the same cycle; halt wins.
    latFixed = 3;
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 1, 32'h0000_0200, 1, 0);
    checkOutput("halt_flag", dlx_word'(if_halted), 32'd1);
    checkOutput("halt_addr_kept", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkOutput("halt_req_off", dlx_word'(imem_req), 32'd0);
    idle(2);

    // Asynchronous reset in the middle of a pending fetch.
    asyncReset();
    idle(2);
    asyncReset();
    latFixed = 1;
    idle(2);
    checkOutput("restart_ir", if_id_ir, 32'h11);

    $display("[TB] randomized phase");
    latFixed = 0;
    for (int ep = 0; ep < 6; ep++) begin
      for (int c = 0; c < 80; c++) begin
        applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 7) == 0,
                      ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                  : dlx_word'($urandom_range(0, 1023)),
                      $urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0);
      end
      asyncReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
